// File: rtl/alu_muldiv_param_pkg.sv
// Package shared by the alu_muldiv_param slice.
// Contents:
//   - funct opcode codes understood by the ALU
//   - state_e : top-level FSM state (IDLE, MUL, DIV)
//   - shamt_w(): shift-amount width for a given operand width
package alu_muldiv_pkg;

  localparam logic [5:0] F_SLL   = 6'd0;
  localparam logic [5:0] F_SRL   = 6'd2;
  localparam logic [5:0] F_MFHI  = 6'd16;
  localparam logic [5:0] F_MFLO  = 6'd18;
  localparam logic [5:0] F_MULTU = 6'd25;
  localparam logic [5:0] F_DIVU  = 6'd27;
  localparam logic [5:0] F_ADD   = 6'd32;
  localparam logic [5:0] F_SUB   = 6'd34;
  localparam logic [5:0] F_AND   = 6'd36;
  localparam logic [5:0] F_OR    = 6'd37;
  localparam logic [5:0] F_SLT   = 6'd42;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_e;

  // WIDTH is a power of two, so this is exactly the number of bits that
  // index a bit position within an operand.
  function automatic int shamt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/alu_muldiv_param_if.sv
// Request/response bundle between decode and the alu_muldiv_param block.
//
// Handshake: a request is accepted at a rising clk edge where start==1 and
// busy==0; funct/dataA/dataB are sampled only at that edge. The result is
// signalled by a one-cycle out_valid pulse; dataOut, div_by_zero and
// illegal_op are meaningful when out_valid==1 and hold afterwards. While
// busy==1 start is ignored (no queueing). out_valid of a multi-cycle op
// coincides with busy==0, so a new request may be accepted in that cycle.
//
// Signals:
//   start, funct[5:0], dataA, dataB      : request (master -> slave)
//   dataOut, out_valid, busy,
//   div_by_zero, illegal_op              : response (slave -> master)
//   hi, lo                               : HI/LO registers (observe)
//   state                                : FSM state (debug)
interface alu_muldiv_param_if
  import alu_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) ();

  logic             start;
  logic [5:0]       funct;
  logic [WIDTH-1:0] dataA;
  logic [WIDTH-1:0] dataB;
  logic [WIDTH-1:0] dataOut;
  logic             out_valid;
  logic             busy;
  logic             div_by_zero;
  logic             illegal_op;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  state_e           state;

  modport master (
    output start, funct, dataA, dataB,
    input  dataOut, out_valid, busy, div_by_zero, illegal_op, hi, lo, state
  );

  modport slave (
    input  start, funct, dataA, dataB,
    output dataOut, out_valid, busy, div_by_zero, illegal_op, hi, lo, state
  );

endinterface

// File: rtl/alu_muldiv_param_muldiv_iter.sv
// muldiv_iter: shared iterative datapath for unsigned multiply and
// restoring divide, one step per clock, WIDTH steps per operation.
//
// Ports:
//   clk, reset   : clock, synchronous active-low reset
//   load         : start a new operation with op_a/op_b (ignored mid-op
//                  only by convention of the caller; load always restarts)
//   div_mode     : 0 = multiply, 1 = divide (sampled with load)
//   op_a, op_b   : operands
//   active       : an operation is in flight
//   done         : combinational; high in the cycle whose edge performs the
//                  final step
//   res_hi/lo    : combinational result of the step taken at the next edge;
//                  on done this is {A*B} or {A%B, A/B}
//
// Register use: multiply keeps the partial product in hi_q and the
// not-yet-consumed multiplier bits in lo_q (product bits shift in from the
// top). Divide keeps the partial remainder in hi_q and the dividend bits
// in lo_q, with quotient bits shifting in from the bottom.
module muldiv_iter
  import alu_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             div_mode,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             active,
  output logic             done,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  localparam int CNT_W = shamt_w(WIDTH);

  logic             active_q, active_d;
  logic             div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;

  always_comb begin
    // Multiply step: conditionally add the multiplicand, then shift the
    // (WIDTH+1)-bit sum together with the multiplier register right by one.
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    // Divide step: bring the next dividend bit into the remainder and try
    // to subtract the divisor; a borrow (msb set) means restore.
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_q};

    if (div_q) begin
      step_hi = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
      step_lo = {lo_q[WIDTH-2:0], ~div_diff[WIDTH]};
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
    end

    done = active_q && (cnt_q == CNT_W'(WIDTH - 1));

    active_d = active_q;
    div_d    = div_q;
    cnt_d    = cnt_q;
    opnd_d   = opnd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    if (load) begin
      active_d = 1'b1;
      div_d    = div_mode;
      cnt_d    = '0;
      opnd_d   = div_mode ? op_b : op_a;
      hi_d     = '0;
      lo_d     = div_mode ? op_a : op_b;
    end else if (active_q) begin
      hi_d  = step_hi;
      lo_d  = step_lo;
      cnt_d = cnt_q + CNT_W'(1);
      if (done) begin
        active_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      active_q <= 1'b0;
      div_q    <= 1'b0;
      cnt_q    <= '0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      active_q <= active_d;
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      opnd_q   <= opnd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign active = active_q;
  assign res_hi = step_hi;
  assign res_lo = step_lo;

endmodule

// File: rtl/alu_muldiv_param.sv
// alu_muldiv_param: parametrised ALU with iterative MULTU/DIVU and HI/LO.
//
// Single-cycle ops (AND, OR, ADD, SUB, SLT, SLL, SRL, MFHI, MFLO, unknown)
// register their result at the accept edge and pulse out_valid in the
// following cycle. MULTU and DIVU (non-zero divisor) keep busy high for
// WIDTH cycles, write {hi,lo} at the final step and then pulse out_valid
// with dataOut=0. DIVU by zero completes immediately with hi=dataA,
// lo=all ones and div_by_zero set. WIDTH must be >= 4 and a power of two.
//
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-low; clears all state and aborts MULTU/DIVU
//   bus   : alu_muldiv_param_if.slave (request, response, hi/lo, state)
module alu_muldiv_param
  import alu_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                clk,
  input  logic                reset,
  alu_muldiv_param_if.slave   bus
);

  localparam int SHAMT_W = shamt_w(WIDTH);

  state_e           state_q, state_d;
  logic             busy_q, busy_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dbz_q, dbz_d;
  logic             ill_q, ill_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic               accept;
  logic               iter_load;
  logic               iter_div;
  logic               iter_active;
  logic               iter_done;
  logic [WIDTH-1:0]   iter_hi;
  logic [WIDTH-1:0]   iter_lo;
  logic [SHAMT_W-1:0] shamt;
  logic               slt_lt;

  assign accept = bus.start && !busy_q;
  assign shamt  = bus.dataB[SHAMT_W-1:0];
  assign slt_lt = $signed(bus.dataA) < $signed(bus.dataB);

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    out_valid_d = 1'b0;
    dout_d      = dout_q;
    dbz_d       = dbz_q;
    ill_d       = ill_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    iter_load   = 1'b0;
    iter_div    = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          // Default for a completing single-cycle op; flags clear unless set.
          out_valid_d = 1'b1;
          dbz_d       = 1'b0;
          ill_d       = 1'b0;
          case (bus.funct)
            F_AND:  dout_d = bus.dataA & bus.dataB;
            F_OR:   dout_d = bus.dataA | bus.dataB;
            F_ADD:  dout_d = bus.dataA + bus.dataB;
            F_SUB:  dout_d = bus.dataA - bus.dataB;
            F_SLT:  dout_d = {{(WIDTH-1){1'b0}}, slt_lt};
            F_SLL:  dout_d = bus.dataA << shamt;
            F_SRL:  dout_d = bus.dataA >> shamt;
            F_MFHI: dout_d = hi_q;
            F_MFLO: dout_d = lo_q;
            F_MULTU: begin
              out_valid_d = 1'b0;
              dbz_d       = dbz_q;
              ill_d       = ill_q;
              iter_load   = 1'b1;
              state_d     = MUL;
              busy_d      = 1'b1;
            end
            F_DIVU: begin
              if (bus.dataB == '0) begin
                dout_d = '0;
                hi_d   = bus.dataA;
                lo_d   = '1;
                dbz_d  = 1'b1;
              end else begin
                out_valid_d = 1'b0;
                dbz_d       = dbz_q;
                ill_d       = ill_q;
                iter_load   = 1'b1;
                iter_div    = 1'b1;
                state_d     = DIV;
                busy_d      = 1'b1;
              end
            end
            default: begin
              dout_d = '0;
              ill_d  = 1'b1;
            end
          endcase
        end
      end
      MUL, DIV: begin
        if (iter_done) begin
          hi_d        = iter_hi;
          lo_d        = iter_lo;
          dout_d      = '0;
          dbz_d       = 1'b0;
          ill_d       = 1'b0;
          out_valid_d = 1'b1;
          state_d     = IDLE;
          busy_d      = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      dbz_q       <= 1'b0;
      ill_q       <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      dout_q      <= dout_d;
      dbz_q       <= dbz_d;
      ill_q       <= ill_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
    end
  end

  muldiv_iter #(
    .WIDTH(WIDTH)
  ) u_iter (
    .clk     (clk),
    .reset   (reset),
    .load    (iter_load),
    .div_mode(iter_div),
    .op_a    (bus.dataA),
    .op_b    (bus.dataB),
    .active  (iter_active),
    .done    (iter_done),
    .res_hi  (iter_hi),
    .res_lo  (iter_lo)
  );

  // The iterator's own activity flag mirrors busy; it is kept for
  // observation only.
  logic iter_active_unused;
  assign iter_active_unused = iter_active;

  assign bus.dataOut     = dout_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.busy        = busy_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.illegal_op  = ill_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_alu_muldiv_param.sv
// Testbench for alu_muldiv_param: a WIDTH=32 and a WIDTH=8 instance.
module tb_alu_muldiv_param;
  import alu_muldiv_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_muldiv_param_if #(.WIDTH(32)) bus32 ();
  alu_muldiv_param_if #(.WIDTH(8))  bus8 ();

  alu_muldiv_param #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .bus(bus32));
  alu_muldiv_param #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(bus8));

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] m_hi, m_lo;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model from the architectural rules (32-bit).
  function automatic void model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] d, output logic dbz, output logic ill,
                                output int busy_cycles);
    logic [63:0] p;
    d = 0; dbz = 0; ill = 0; busy_cycles = 0;
    case (f)
      6'd36: d = a & b;
      6'd37: d = a | b;
      6'd32: d = a + b;
      6'd34: d = a - b;
      6'd42: d = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6'd0:  d = a << (b % 32);
      6'd2:  d = a >> (b % 32);
      6'd16: d = m_hi;
      6'd18: d = m_lo;
      6'd25: begin p = {32'd0, a} * {32'd0, b}; m_hi = p[63:32]; m_lo = p[31:0]; busy_cycles = 32; end
      6'd27: begin
        if (b == 0) begin m_hi = a; m_lo = 32'hFFFF_FFFF; dbz = 1; end
        else begin m_lo = a / b; m_hi = a % b; busy_cycles = 32; end
      end
      default: ill = 1;
    endcase
  endfunction

  // ---------------- drivers ----------------
  task automatic run32(input string tag, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] e_d, input logic [31:0] e_hi, input logic [31:0] e_lo,
                       input logic e_dbz, input logic e_ill, input int e_busy);
    int cyc = 0;
    int busy_n = 0;
    bus32.start = 1'b1; bus32.funct = f; bus32.dataA = a; bus32.dataB = b;
    @(posedge clk); #1;
    // Operands change after accept; the DUT must not resample them.
    bus32.start = 1'b0; bus32.dataA = $urandom; bus32.dataB = $urandom;
    bus32.funct = 6'($urandom_range(0, 63));
    while (!bus32.out_valid && cyc < 40) begin
      if (bus32.busy) busy_n++;
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, " out_valid"}, 64'(bus32.out_valid), 64'd1);
    check({tag, " dataOut"}, 64'(bus32.dataOut), 64'(e_d));
    check({tag, " hi"}, 64'(bus32.hi), 64'(e_hi));
    check({tag, " lo"}, 64'(bus32.lo), 64'(e_lo));
    check({tag, " div_by_zero"}, 64'(bus32.div_by_zero), 64'(e_dbz));
    check({tag, " illegal_op"}, 64'(bus32.illegal_op), 64'(e_ill));
    check({tag, " busy_cycles"}, 64'(busy_n), 64'(e_busy));
  endtask

  task automatic run_model32(input string tag, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] d;
    logic dbz, ill;
    int bc;
    model(f, a, b, d, dbz, ill, bc);
    run32(tag, f, a, b, d, m_hi, m_lo, dbz, ill, bc);
  endtask

  task automatic run8(input string tag, input logic [5:0] f, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] e_d, input logic [7:0] e_hi, input logic [7:0] e_lo, input int e_busy);
    int cyc = 0;
    int busy_n = 0;
    bus8.start = 1'b1; bus8.funct = f; bus8.dataA = a; bus8.dataB = b;
    @(posedge clk); #1;
    bus8.start = 1'b0; bus8.dataA = 8'($urandom); bus8.dataB = 8'($urandom);
    while (!bus8.out_valid && cyc < 20) begin
      if (bus8.busy) busy_n++;
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, " out_valid"}, 64'(bus8.out_valid), 64'd1);
    check({tag, " dataOut"}, 64'(bus8.dataOut), 64'(e_d));
    check({tag, " hi"}, 64'(bus8.hi), 64'(e_hi));
    check({tag, " lo"}, 64'(bus8.lo), 64'(e_lo));
    check({tag, " busy_cycles"}, 64'(busy_n), 64'(e_busy));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [5:0]  f;
    logic [31:0] a, b, d, hi, lo;
    logic        dbz, ill;
    int          busy;
  } vec_t;

  vec_t vecs[16];

  initial begin
    logic [31:0] d;
    logic dbz, ill;
    int bc, pulses, busy_n;
    logic [5:0] codes[12];

    vecs[0]  = '{6'd32, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 32'h0,         32'h0,         1'b0, 1'b0, 0};
    vecs[1]  = '{6'd34, 32'h5,         32'h7,         32'hFFFF_FFFE, 32'h0,         32'h0,         1'b0, 1'b0, 0};
    vecs[2]  = '{6'd42, 32'hFFFF_FFFF, 32'h1,         32'h1,         32'h0,         32'h0,         1'b0, 1'b0, 0};
    vecs[3]  = '{6'd42, 32'h1,         32'hFFFF_FFFF, 32'h0,         32'h0,         32'h0,         1'b0, 1'b0, 0};
    vecs[4]  = '{6'd36, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234, 32'h0,         32'h0,         1'b0, 1'b0, 0};
    vecs[5]  = '{6'd37, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F, 32'h0,         32'h0,         1'b0, 1'b0, 0};
    vecs[6]  = '{6'd0,  32'h1,         32'h21,        32'h2,         32'h0,         32'h0,         1'b0, 1'b0, 0};
    vecs[7]  = '{6'd2,  32'h8000_0000, 32'd31,        32'h1,         32'h0,         32'h0,         1'b0, 1'b0, 0};
    vecs[8]  = '{6'd25, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         32'hFFFF_FFFE, 32'h1,         1'b0, 1'b0, 32};
    vecs[9]  = '{6'd16, 32'h0,         32'h0,         32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'h1,         1'b0, 1'b0, 0};
    vecs[10] = '{6'd18, 32'h0,         32'h0,         32'h1,         32'hFFFF_FFFE, 32'h1,         1'b0, 1'b0, 0};
    vecs[11] = '{6'd27, 32'd100,       32'd7,         32'h0,         32'd2,         32'd14,        1'b0, 1'b0, 32};
    vecs[12] = '{6'd27, 32'd1234,      32'd0,         32'h0,         32'd1234,      32'hFFFF_FFFF, 1'b1, 1'b0, 0};
    vecs[13] = '{6'd63, 32'h55,        32'h66,        32'h0,         32'd1234,      32'hFFFF_FFFF, 1'b0, 1'b1, 0};
    vecs[14] = '{6'd18, 32'h0,         32'h0,         32'hFFFF_FFFF, 32'd1234,      32'hFFFF_FFFF, 1'b0, 1'b0, 0};
    vecs[15] = '{6'd32, 32'hFFFF_FFFF, 32'h1,         32'h0,         32'd1234,      32'hFFFF_FFFF, 1'b0, 1'b0, 0};

    codes = '{6'd36, 6'd37, 6'd32, 6'd34, 6'd42, 6'd0, 6'd2, 6'd16, 6'd18, 6'd25, 6'd27, 6'd51};

    bus32.start = 0; bus32.funct = 0; bus32.dataA = 0; bus32.dataB = 0;
    bus8.start = 0;  bus8.funct = 0;  bus8.dataA = 0;  bus8.dataB = 0;
    m_hi = 0; m_lo = 0;

    // ---- reset state ----
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst dataOut", 64'(bus32.dataOut), 64'd0);
    check("rst out_valid", 64'(bus32.out_valid), 64'd0);
    check("rst busy", 64'(bus32.busy), 64'd0);
    check("rst hi", 64'(bus32.hi), 64'd0);
    check("rst lo", 64'(bus32.lo), 64'd0);
    check("rst flags", 64'({bus32.div_by_zero, bus32.illegal_op}), 64'd0);
    check("rst state", 64'(bus32.state), 64'(IDLE));
    reset = 1'b1;
    @(posedge clk); #1;

    // ---- table ----
    for (int i = 0; i < 16; i++) begin
      run32($sformatf("vec%0d", i), vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].d,
            vecs[i].hi, vecs[i].lo, vecs[i].dbz, vecs[i].ill, vecs[i].busy);
      m_hi = vecs[i].hi;
      m_lo = vecs[i].lo;
    end
    @(posedge clk); #1;

    // ---- back-to-back single-cycle ops ----
    model(6'd32, 32'h7FFF_FFFF, 32'h1, d, dbz, ill, bc); exp_q.push_back(d);
    model(6'd34, 32'h5, 32'h7, d, dbz, ill, bc);         exp_q.push_back(d);
    model(6'd42, 32'hFFFF_FFFF, 32'h1, d, dbz, ill, bc); exp_q.push_back(d);
    bus32.start = 1; bus32.funct = 6'd32; bus32.dataA = 32'h7FFF_FFFF; bus32.dataB = 32'h1;
    @(posedge clk); #1;
    check("b2b0 out_valid", 64'({bus32.out_valid, bus32.busy}), 64'b10);
    check("b2b0 dataOut", 64'(bus32.dataOut), 64'(exp_q.pop_front()));
    bus32.funct = 6'd34; bus32.dataA = 32'h5; bus32.dataB = 32'h7;
    @(posedge clk); #1;
    check("b2b1 out_valid", 64'({bus32.out_valid, bus32.busy}), 64'b10);
    check("b2b1 dataOut", 64'(bus32.dataOut), 64'(exp_q.pop_front()));
    bus32.funct = 6'd42; bus32.dataA = 32'hFFFF_FFFF; bus32.dataB = 32'h1;
    @(posedge clk); #1;
    check("b2b2 out_valid", 64'({bus32.out_valid, bus32.busy}), 64'b10);
    check("b2b2 dataOut", 64'(bus32.dataOut), 64'(exp_q.pop_front()));
    bus32.start = 0;
    @(posedge clk); #1;
    check("b2b pulse end", 64'(bus32.out_valid), 64'd0);
    check("b2b dataOut hold", 64'(bus32.dataOut), 64'd1);

    // ---- start while busy is dropped ----
    bus32.start = 1; bus32.funct = 6'd25; bus32.dataA = 32'd3; bus32.dataB = 32'd4;
    @(posedge clk); #1;
    bus32.funct = 6'd32; bus32.dataA = 32'd1; bus32.dataB = 32'd1;
    busy_n = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus32.out_valid) break;
      if (bus32.busy) busy_n++;
      if (i == 5) begin bus32.funct = 6'd25; bus32.dataA = 32'd5; bus32.dataB = 32'd5; end
      @(posedge clk); #1;
    end
    bus32.start = 0;
    check("drop out_valid", 64'(bus32.out_valid), 64'd1);
    check("drop busy_cycles", 64'(busy_n), 64'd32);
    check("drop lo", 64'(bus32.lo), 64'd12);
    check("drop hi", 64'(bus32.hi), 64'd0);
    check("drop dataOut", 64'(bus32.dataOut), 64'd0);
    pulses = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (bus32.out_valid || bus32.busy) pulses++;
    end
    check("drop no extra", 64'(pulses), 64'd0);
    m_hi = 0; m_lo = 12;

    // ---- randomized against the model ----
    for (int i = 0; i < 60; i++) begin
      logic [5:0] f;
      logic [31:0] a, b;
      f = codes[$urandom_range(0, 11)];
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      run_model32($sformatf("rnd%0d f=%0d", i, f), f, a, b);
    end

    // ---- reset mid-MULTU ----
    run_model32("pre", 6'd25, 32'h0001_2345, 32'hABCD_6789);
    bus32.start = 1; bus32.funct = 6'd25; bus32.dataA = 32'd7; bus32.dataB = 32'd9;
    @(posedge clk); #1;
    bus32.start = 0;
    repeat (9) @(posedge clk);
    #1;
    check("abort busy before", 64'(bus32.busy), 64'd1);
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    check("abort busy", 64'(bus32.busy), 64'd0);
    check("abort hi", 64'(bus32.hi), 64'd0);
    check("abort lo", 64'(bus32.lo), 64'd0);
    check("abort out_valid", 64'(bus32.out_valid), 64'd0);
    pulses = 0;
    repeat (36) begin
      @(posedge clk); #1;
      if (bus32.out_valid) pulses++;
    end
    check("abort no pulse", 64'(pulses), 64'd0);
    // reset together with start: request dropped
    reset = 1'b0; bus32.start = 1; bus32.funct = 6'd32; bus32.dataA = 32'd1; bus32.dataB = 32'd2;
    @(posedge clk); #1;
    reset = 1'b1; bus32.start = 0;
    check("rst+start out_valid", 64'(bus32.out_valid), 64'd0);
    m_hi = 0; m_lo = 0;
    run_model32("post mflo", 6'd18, 32'h0, 32'h0);
    run32("post illegal", 6'd63, 32'h1234, 32'h5678, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 0);

    // ---- WIDTH=8 instance ----
    run8("w8 mul", 6'd25, 8'hFF, 8'hFF, 8'h00, 8'hFE, 8'h01, 8);
    run8("w8 sll", 6'd0,  8'h01, 8'h09, 8'h02, 8'hFE, 8'h01, 0);
    run8("w8 srl", 6'd2,  8'h80, 8'h07, 8'h01, 8'hFE, 8'h01, 0);
    run8("w8 div", 6'd27, 8'd200, 8'd9, 8'h00, 8'd2, 8'd22, 8);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
